// File: rtl/alu_shifter_pipe.sv
// Pipelined log shifter (SLL/SRA/ROR/SRL) with zero/sign/ovfl flags.
// Each stage resolves one shift-amount bit. The whole pipe freezes while the output is stalled.
module alu_shifter_pipe #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               sign,
  output logic               ovfl
);
  localparam int L = SHAMT_W - 1;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                input logic [1:0] m,
                                                input int unsigned sh);
    case (m)
      2'b00:   return d << sh;
      2'b01:   return $signed(d) >>> sh;
      2'b10:   return (d >> sh) | (d << (WIDTH - sh));
      default: return d >> sh;
    endcase
  endfunction

  // SLL overflows when any of the top sh+1 bits of the operand differs from its sign bit
  function automatic logic sll_ovfl(input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] sh);
    logic o;
    o = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (i >= WIDTH - 1 - int'(sh) && d[i] != d[WIDTH-1]) o = 1'b1;
    return o;
  endfunction

  logic stall, en;

  logic [SHAMT_W-1:0]                  s_vld;
  logic [SHAMT_W-1:0][WIDTH-1:0]       s_data, s_a, shifted;
  logic [SHAMT_W-1:0][SHAMT_W-1:0]     s_b;
  logic [SHAMT_W-1:0][1:0]             s_mode;

  logic [SHAMT_W-1:0]                  vld_pipe;
  logic [SHAMT_W-1:0][WIDTH-1:0]       data_q;
  logic [L-1:0][WIDTH-1:0]             a_q;
  logic [L-1:0][SHAMT_W-1:0]           b_q;
  logic [L-1:0][1:0]                   mode_q;

  assign stall     = vld_pipe[L] & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe[L];
  assign result    = data_q[L];

  assign s_vld[0]  = in_valid;
  assign s_data[0] = a;
  assign s_a[0]    = a;
  assign s_b[0]    = b;
  assign s_mode[0] = mode;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;

    assign shifted[k] = s_b[k][k] ? shift_by(s_data[k], s_mode[k], SH) : s_data[k];

    // Data only loads on valid beats so the output stays at 0 after reset until real data arrives
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe[k] <= 1'b0;
        data_q[k]   <= '0;
      end else if (en) begin
        vld_pipe[k] <= s_vld[k];
        if (s_vld[k]) data_q[k] <= shifted[k];
      end
    end

    if (k < L) begin : g_fwd
      assign s_vld[k+1]  = vld_pipe[k];
      assign s_data[k+1] = data_q[k];
      assign s_a[k+1]    = a_q[k];
      assign s_b[k+1]    = b_q[k];
      assign s_mode[k+1] = mode_q[k];

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q[k]    <= '0;
          b_q[k]    <= '0;
          mode_q[k] <= '0;
        end else if (en && s_vld[k]) begin
          a_q[k]    <= s_a[k];
          b_q[k]    <= s_b[k];
          mode_q[k] <= s_mode[k];
        end
      end
    end else begin : g_flags
      always_ff @(posedge clk) begin
        if (rst) begin
          zero <= 1'b0;
          sign <= 1'b0;
          ovfl <= 1'b0;
        end else if (en && s_vld[k]) begin
          zero <= (shifted[k] == '0);
          sign <= shifted[k][WIDTH-1];
          ovfl <= (s_mode[k] == 2'b00) && sll_ovfl(s_a[k], s_b[k]);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Self-checking bench for alu_shifter_pipe: directed vectors plus random traffic against a
// bit-level reference model with an expected-output queue.
module tb_alu_shifter_pipe;
  localparam int W  = 16;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  a;
  logic [SW-1:0] b;
  logic [1:0]    mode;
  logic          out_valid, out_ready;
  logic [W-1:0]  result;
  logic          zero, sign, ovfl;

  always #5 clk = ~clk;

  alu_shifter_pipe #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .sign(sign), .ovfl(ovfl)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         z, s, o;
    int           acc;
    int           stall_at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, stall_total = 0, checks = 0, failures = 0;

  function automatic exp_t model(input logic [W-1:0] aa, input int bb, input logic [1:0] mm);
    exp_t e;
    int src;
    logic [3:0] idx;
    e.res = '0;
    for (int i = 0; i < W; i++) begin
      src = (mm == 2'b00) ? i - bb : i + bb;
      idx = 4'(src);
      case (mm)
        2'b00:   e.res[i] = (src >= 0) ? aa[idx] : 1'b0;
        2'b01:   e.res[i] = (src < W) ? aa[idx] : aa[W-1];
        2'b10:   e.res[i] = aa[4'(src % W)];
        default: e.res[i] = (src < W) ? aa[idx] : 1'b0;
      endcase
    end
    e.z = (e.res == '0);
    e.s = e.res[W-1];
    e.o = (mm == 2'b00) && (($signed(e.res) >>> bb) != $signed(aa));
    e.acc = 0;
    e.stall_at = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic s, input logic o);
    exp_t e;
    e.res = r; e.z = z; e.s = s; e.o = o; e.acc = 0; e.stall_at = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model, update the scoreboard, advance.
  task automatic tick(input logic v, input logic [W-1:0] aa, input logic [SW-1:0] bb,
                      input logic [1:0] mm, input logic ordy, input exp_t ex);
    logic exp_valid, stl;
    exp_t e;
    in_valid = v; a = aa; b = bb; mode = mm; out_ready = ordy;
    #1;
    exp_valid = (q.size() > 0) && (cyc == q[0].acc + SW + (stall_total - q[0].stall_at));
    stl = exp_valid && !ordy;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("in_ready", 32'(in_ready), 32'(!stl));
    if (exp_valid) begin
      chk("result", 32'(result), 32'(q[0].res));
      chk("zero", 32'(zero), 32'(q[0].z));
      chk("sign", 32'(sign), 32'(q[0].s));
      chk("ovfl", 32'(ovfl), 32'(q[0].o));
      if (ordy) void'(q.pop_front());
    end
    if (v && !stl) begin
      e = ex;
      e.acc = cyc;
      e.stall_at = stall_total;
      q.push_back(e);
    end
    if (stl) stall_total++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, 2'b00, ordy, mk('0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic issue_rand(input logic ordy);
    logic [W-1:0]  ra;
    logic [SW-1:0] rb;
    logic [1:0]    rm;
    ra = W'($urandom);
    rb = SW'($urandom_range(0, W - 1));
    rm = 2'($urandom_range(0, 3));
    tick(1'b1, ra, rb, rm, ordy, model(ra, int'(rb), rm));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = W'($urandom); b = '0; mode = '0;
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    q.delete();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_ovfl", 32'(ovfl), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    // Single SLL, isolated so latency is observed cleanly
    tick(1'b1, 16'h1234, 4'd3, 2'b00, 1'b1, mk(16'h91A0, 1'b0, 1'b1, 1'b1));
    repeat (6) idle(1'b1);

    // Directed vectors back to back
    tick(1'b1, 16'hEDCC, 4'd3,  2'b01, 1'b1, mk(16'hFDB9, 1'b0, 1'b1, 1'b0));
    tick(1'b1, 16'hEDCC, 4'd3,  2'b11, 1'b1, mk(16'h1DB9, 1'b0, 1'b0, 1'b0));
    tick(1'b1, 16'hF000, 4'd4,  2'b10, 1'b1, mk(16'h0F00, 1'b0, 1'b0, 1'b0));
    tick(1'b1, 16'h0001, 4'd15, 2'b10, 1'b1, mk(16'h0002, 1'b0, 1'b0, 1'b0));
    tick(1'b1, 16'h8000, 4'd1,  2'b00, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    tick(1'b1, 16'h0000, 4'd0,  2'b01, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    tick(1'b1, 16'hA5C3, 4'd0,  2'b00, 1'b1, mk(16'hA5C3, 1'b0, 1'b1, 1'b0));
    tick(1'b1, 16'h8001, 4'd15, 2'b11, 1'b1, mk(16'h0001, 1'b0, 1'b0, 1'b0));
    repeat (6) idle(1'b1);

    // Back-to-back stream of 8, then 3 stall cycles with input still offered
    repeat (8) issue_rand(1'b1);
    repeat (3) issue_rand(1'b0);
    repeat (4) issue_rand(1'b1);
    repeat (6) idle(1'b1);

    // Random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) issue_rand($urandom_range(0, 3) != 0);
      else idle($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);

    // Reset with three operations in flight: nothing may emerge afterwards
    repeat (3) issue_rand(1'b1);
    do_reset(1);
    repeat (5) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_shifter_pipe.md
Name: alu_shifter_pipe

Overview:
- Pipelined, parametrised successor to the 16-bit combinational ALU shifter.
- Performs SLL, SRA, ROR and a new SRL mode over WIDTH bits as a log-shifter. Each stage resolves one bit of the shift amount and is registered.
- A valid/ready handshake on both sides allows back-pressure from the writeback stage. Flags (zero, sign, ovfl) are produced alongside the result for the flag register.

Parameters:
- WIDTH, 16: data width. Must be a power of two, >= 4.
- SHAMT_W, $clog2(WIDTH): shift-amount width. This is also the pipeline depth (stage count).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set on a/b/mode is valid.
- in_ready  output  1  pipeline can accept an operand this cycle.
- a  input  WIDTH  value to shift.
- b  input  SHAMT_W  shift amount, 0..WIDTH-1.
- mode  input  2  00 SLL, 01 SRA, 10 ROR, 11 SRL.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  shifted value.
- zero  output  1  result == 0.
- sign  output  1  result[WIDTH-1].
- ovfl  output  1  signed overflow on SLL; 0 for the other modes.

Behaviour:
- Reset: clk and rst as named; rst is synchronous and active-high. All stage valid bits clear, so out_valid=0, result=0, zero=0, sign=0, ovfl=0. in_ready=1 in the first cycle after reset. rst overrides any handshake in the same cycle, and in-flight operations are discarded with no output.
- Pipeline structure:
  - Stage k (k=0..SHAMT_W-1) registers the data shifted by (b[k] ? 2^k : 0) in the direction given by mode.
  - mode, the remaining b bits, the original a (for ovfl), and a valid bit travel with the data.
- Latency: an operand accepted in cycle N (in_valid & in_ready) appears with out_valid=1 in cycle N+SHAMT_W, assuming no stall (4 cycles at WIDTH=16).
- Throughput: one operation per cycle when out_ready=1.
- Stall:
  - stall = out_valid & ~out_ready. While stall=1, every stage holds and in_ready=0.
  - in_ready = ~stall, a purely combinational function of the output stage.
  - Bubbles do not compress; the pipeline is rigid.
- Output stability: while out_valid=1 and out_ready=0, result, zero, sign and ovfl remain stable.
- Shift semantics:
  - SLL fills zeros at the LSB.
  - SRA replicates a[WIDTH-1].
  - SRL fills zeros at the MSB.
  - ROR rotates right: bit i comes from bit (i+b) mod WIDTH.
  - b=0 yields result=a in all modes. The full range 0..WIDTH-1 is legal; there is no modulo fault.
- Flags:
  - Flags are computed on the final stage's data and registered with it.
  - For SLL, ovfl=1 iff ($signed(result) >>> b) != $signed(a), i.e. any shifted-out bit or the new MSB differs from the original sign.
  - ovfl=0 for SRA, SRL and ROR.
  - zero and sign are valid in all modes.
- Unused inputs: a, b and mode are ignored when in_valid=0. Output data when out_valid=0 is don't-care, except after reset, when it is 0.
- Simultaneous accept: if out_valid & out_ready and in_valid in the same cycle, the pipeline advances and accepts the new operand with no bubble.

Test Plan:
- a=16'h1234, b=3, mode=00, out_ready=1 -> out_valid exactly 4 cycles after accept, result=16'h91A0, ovfl=1, sign=1, zero=0.
- a=16'hEDCC, b=3, mode=01 -> result=16'hFDB9, sign=1, ovfl=0. Same a with mode=11 -> result=16'h1DB9, sign=0.
- a=16'hF000, b=4, mode=10 -> result=16'h0F00. Then a=16'h0001, b=15, mode=10 -> result=16'h0002.
- Back-to-back stream of 8 operations with out_ready=1 -> 8 consecutive out_valid cycles in issue order. Then hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 and result stable over those 3 cycles, with no loss or duplication afterwards.
- a=16'h8000, b=1, mode=00 -> result=0, zero=1, ovfl=1. a=16'h0000, b=0, mode=01 -> zero=1, ovfl=0.
- Assert rst for 1 cycle with 3 operations in flight -> next cycle out_valid=0, result=0, in_ready=1; no stale result emerges in the following 4 cycles.
